// File: rtl/alu_uart_interface_if.sv
// alu_uart_interface_if
//   Bundles the UART receive/transmit handshake and the ALU operand/result
//   bus seen by the sequencer.
//   master : sequencer side (drives o_*, samples i_*)
//   slave  : environment side (UART rx/tx plus ALU)
//   i_rx_data/i_rx_done : received byte and its one-cycle strobe
//   i_alu_res           : combinational ALU result
//   i_tx_done           : transmitter finished strobe
//   o_alu_a/b/op        : registered ALU inputs
//   o_tx_data/o_tx_start: result byte and one-cycle transmit request
//   o_busy/o_overrun    : status
interface alu_uart_interface_if #(
  parameter int N_BITS = 8,
  parameter int N_OP   = 6
);
  logic [N_BITS-1:0] i_rx_data;
  logic              i_rx_done;
  logic [N_BITS-1:0] i_alu_res;
  logic              i_tx_done;
  logic [N_BITS-1:0] o_alu_a;
  logic [N_BITS-1:0] o_alu_b;
  logic [N_OP-1:0]   o_alu_op;
  logic [N_BITS-1:0] o_tx_data;
  logic              o_tx_start;
  logic              o_busy;
  logic              o_overrun;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_res, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_res, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun
  );
endinterface

// File: rtl/alu_uart_interface.sv
// alu_uart_interface
//   Collects A, B and OP as three consecutive UART bytes, drives them to a
//   combinational ALU, captures the result and hands it to the UART
//   transmitter with a start/done handshake.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : alu_uart_interface_if.master (UART rx/tx + ALU signals)
module alu_uart_interface #(
  parameter int N_BITS  = 8,
  parameter int N_OP    = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  alu_uart_interface_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, CALC, SEND, WAIT_TX
  } state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [N_OP-1:0]   op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              busy;

  assign busy = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    case (state_q)
      GET_A: begin
        cnt_d = '0;
        if (bus.i_rx_done) begin
          a_d     = bus.i_rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (bus.i_rx_done) begin
          b_d     = bus.i_rx_data;
          cnt_d   = '0;
          state_d = GET_OP;
        end else if (cnt_q == CNT_LAST) begin
          // inter-byte gap too long: drop the partial command
          cnt_d   = '0;
          state_d = GET_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GET_OP: begin
        if (bus.i_rx_done) begin
          op_d    = bus.i_rx_data[N_OP-1:0];
          cnt_d   = '0;
          state_d = CALC;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = GET_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CALC: begin
        // operands settled on the ALU since the OP edge; latch its result
        tx_d    = bus.i_alu_res;
        state_d = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (bus.i_tx_done) state_d = GET_A;
      default: state_d = GET_A;
    endcase
    // bytes arriving while busy are dropped, including one coincident with i_tx_done
    if (busy && bus.i_rx_done) ovr_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // start/busy decoded from the state register so reset drops them at once
  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_tx_data  = tx_q;
  assign bus.o_tx_start = (state_q == SEND);
  assign bus.o_busy     = busy;
  assign bus.o_overrun  = ovr_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
module tb_alu_uart_interface;
  localparam int N_BITS  = 8;
  localparam int N_OP    = 6;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;

  alu_uart_interface_if #(.N_BITS(N_BITS), .N_OP(N_OP)) bus ();

  alu_uart_interface #(.N_BITS(N_BITS), .N_OP(N_OP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // reference ALU: MIPS-style function codes
  always_comb begin
    case (bus.o_alu_op)
      6'h20:   bus.i_alu_res = bus.o_alu_a + bus.o_alu_b;
      6'h22:   bus.i_alu_res = bus.o_alu_a - bus.o_alu_b;
      6'h24:   bus.i_alu_res = bus.o_alu_a & bus.o_alu_b;
      6'h25:   bus.i_alu_res = bus.o_alu_a | bus.o_alu_b;
      default: bus.i_alu_res = 8'h00;
    endcase
  end

  always @(negedge clk) if (bus.o_tx_start) n_start++;

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_tx();
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_rx_data = '0; bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
    rst = 1'b1;
    idle(2);
    n_cmp++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_tx_data} !== 24'h0) begin n_bad++;
      $display("FAIL rst_regs got %h/%h/%h want 0", bus.o_alu_a, bus.o_alu_b, bus.o_tx_data); end
    n_cmp++; if (bus.o_alu_op !== 6'h0) begin n_bad++; $display("FAIL rst_op got %h want 0", bus.o_alu_op); end
    n_cmp++; if ({bus.o_tx_start, bus.o_busy, bus.o_overrun} !== 3'b000) begin n_bad++;
      $display("FAIL rst_status got %b want 000", {bus.o_tx_start, bus.o_busy, bus.o_overrun}); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_add();
    int s0;
    s0 = n_start;
    send_byte(8'h05);
    n_cmp++; if (bus.o_alu_a !== 8'h05) begin n_bad++; $display("FAIL add_a got %h want 05", bus.o_alu_a); end
    send_byte(8'h05);
    n_cmp++; if (bus.o_alu_b !== 8'h05) begin n_bad++; $display("FAIL add_b got %h want 05", bus.o_alu_b); end
    send_byte(8'h20);                 // edge k
    n_cmp++; if (bus.o_alu_op !== 6'h20) begin n_bad++; $display("FAIL add_op got %h want 20", bus.o_alu_op); end
    n_cmp++; if ({bus.o_busy, bus.o_tx_start} !== 2'b10) begin n_bad++;
      $display("FAIL add_k busy/start got %b want 10", {bus.o_busy, bus.o_tx_start}); end
    idle(1);                          // edge k+1
    n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_bad++; $display("FAIL add_start got %b want 1", bus.o_tx_start); end
    n_cmp++; if (bus.o_tx_data !== 8'h0A) begin n_bad++; $display("FAIL add_res got %h want 0a", bus.o_tx_data); end
    idle(5);
    n_cmp++; if ({bus.o_busy, bus.o_tx_start} !== 2'b10) begin n_bad++;
      $display("FAIL add_wait busy/start got %b want 10", {bus.o_busy, bus.o_tx_start}); end
    finish_tx();
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL add_done busy got %b want 0", bus.o_busy); end
    n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL add_pulses got %0d want 1", n_start - s0); end
  endtask

  task automatic test_sub_and();
    send_byte(8'h05); send_byte(8'h0A); send_byte(8'h22);
    idle(1);
    n_cmp++; if (bus.o_tx_data !== 8'hFB) begin n_bad++; $display("FAIL sub_res got %h want fb", bus.o_tx_data); end
    idle(1); finish_tx();
    send_byte(8'h1F); send_byte(8'hF8); send_byte(8'hE4);
    n_cmp++; if (bus.o_alu_op !== 6'h24) begin n_bad++; $display("FAIL and_op got %h want 24", bus.o_alu_op); end
    idle(1);
    n_cmp++; if (bus.o_tx_data !== 8'h18) begin n_bad++; $display("FAIL and_res got %h want 18", bus.o_tx_data); end
    idle(1); finish_tx();
  endtask

  task automatic test_timeout();
    int s0;
    s0 = n_start;
    send_byte(8'h11);
    idle(TIMEOUT - 1);                // one short of the limit: still waiting for B
    send_byte(8'h22);
    n_cmp++; if (bus.o_alu_b !== 8'h22) begin n_bad++; $display("FAIL to_edge b got %h want 22", bus.o_alu_b); end
    idle(TIMEOUT);                    // limit reached in GET_OP
    n_cmp++; if ({bus.o_alu_a, bus.o_alu_b} !== 16'h1122) begin n_bad++;
      $display("FAIL to_hold got %h want 1122", {bus.o_alu_a, bus.o_alu_b}); end
    n_cmp++; if ((n_start - s0) !== 0 || bus.o_busy !== 1'b0) begin n_bad++;
      $display("FAIL to_quiet pulses %0d busy %b want 0 0", n_start - s0, bus.o_busy); end
    send_byte(8'h03);
    n_cmp++; if (bus.o_alu_a !== 8'h03) begin n_bad++; $display("FAIL to_newa got %h want 03", bus.o_alu_a); end
    send_byte(8'h04); send_byte(8'h20);
    idle(1);
    n_cmp++; if (bus.o_tx_data !== 8'h07) begin n_bad++; $display("FAIL to_res got %h want 07", bus.o_tx_data); end
    idle(1); finish_tx();
  endtask

  task automatic test_overrun();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h20);
    idle(2);                          // now in WAIT_TX
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_pre got %b want 0", bus.o_overrun); end
    send_byte(8'h55);
    n_cmp++; if (bus.o_overrun !== 1'b1 || bus.o_alu_a !== 8'h01) begin n_bad++;
      $display("FAIL ovr_drop ovr %b a %h want 1 01", bus.o_overrun, bus.o_alu_a); end
    bus.i_tx_done = 1'b1;             // coincident done + byte
    send_byte(8'h66);
    bus.i_tx_done = 1'b0;
    n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_alu_a !== 8'h01) begin n_bad++;
      $display("FAIL ovr_coinc busy %b a %h want 0 01", bus.o_busy, bus.o_alu_a); end
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h20);
    idle(1);
    n_cmp++; if (bus.o_tx_data !== 8'h0F || bus.o_alu_a !== 8'h07) begin n_bad++;
      $display("FAIL ovr_next res %h a %h want 0f 07", bus.o_tx_data, bus.o_alu_a); end
    idle(1); finish_tx();
    n_cmp++; if (bus.o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", bus.o_overrun); end
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = n_start;
    send_byte(8'h0A); send_byte(8'h0B);   // in GET_OP
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_tx_data, bus.o_busy, bus.o_overrun} !== 26'h0) begin n_bad++;
      $display("FAIL rm_op a %h b %h tx %h busy %b ovr %b want all 0", bus.o_alu_a, bus.o_alu_b,
               bus.o_tx_data, bus.o_busy, bus.o_overrun); end
    #1 rst = 1'b0;
    idle(3);
    n_cmp++; if (n_start - s0 !== 0) begin n_bad++; $display("FAIL rm_nopulse got %0d want 0", n_start - s0); end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h20);
    idle(1);                              // in SEND
    n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_bad++; $display("FAIL rm_send got %b want 1", bus.o_tx_start); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.o_tx_start, bus.o_busy, bus.o_tx_data} !== 10'h0) begin n_bad++;
      $display("FAIL rm_send_rst start %b busy %b tx %h want 0 0 00", bus.o_tx_start, bus.o_busy, bus.o_tx_data); end
    #1 rst = 1'b0;
    idle(1);
    send_byte(8'h04); send_byte(8'h04); send_byte(8'h20);
    idle(1);
    n_cmp++; if (bus.o_tx_data !== 8'h08) begin n_bad++; $display("FAIL rm_after got %h want 08", bus.o_tx_data); end
    idle(1); finish_tx();
  endtask

  task automatic test_tx_done_ignored();
    int s0;
    s0 = n_start;
    finish_tx();                          // in GET_A
    n_cmp++; if (bus.o_busy !== 1'b0 || n_start != s0) begin n_bad++;
      $display("FAIL txi_a busy %b pulses %0d want 0 0", bus.o_busy, n_start - s0); end
    send_byte(8'h30);
    finish_tx();                          // in GET_B
    send_byte(8'h0C);
    n_cmp++; if (bus.o_alu_b !== 8'h0C || bus.o_busy !== 1'b0) begin n_bad++;
      $display("FAIL txi_b b %h busy %b want 0c 0", bus.o_alu_b, bus.o_busy); end
    send_byte(8'h25);
    idle(1);
    n_cmp++; if (bus.o_tx_data !== 8'h3C) begin n_bad++; $display("FAIL txi_res got %h want 3c", bus.o_tx_data); end
    idle(1); finish_tx();
    n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL txi_pulses got %0d want 1", n_start - s0); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_tx_done_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
